juiz_rodada: RTL and testbench

- Round referee for the two-player reaction game; the upstream producer of the p1vic/p2vic victory pulses that the scoring/LED block consumes.
- Per round: arms on start, waits a pseudo-random delay, raises the go light, then judges the first valid button press.
- Issues at most one single-cycle victory pulse per round.
- Mirrors the scoreboard's 8-point saturation to flag match end.

---
 rtl/juiz_rodada.sv | 134 +++++++++++++
 tb/tb_juiz_rodada.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/juiz_rodada.sv
// juiz_rodada: round referee for the reaction game; arms, waits a random delay, lights GO,
// judges the first clean press and emits one victory pulse per round.
module juiz_rodada #(
  parameter logic [31:0] DELAY_MIN   = 32'd50_000_000,
  parameter logic [15:0] DELAY_MASK  = 16'h7FFF,
  parameter logic [31:0] TIMEOUT     = 32'd200_000_000,
  parameter logic [31:0] HOLD_CYCLES = 32'd25_000_000,
  parameter logic [3:0]  WIN_POINTS  = 4'd8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic btn1_i,
  input  logic btn2_i,
  output logic p1vic_o,
  output logic p2vic_o,
  output logic go_led_o,
  output logic false_start_o,
  output logic match_over_o
);
  typedef enum logic [2:0] {IDLE, WAIT, GO, VERDICT, HOLD, MATCH_END} state_t;
  state_t      state_q;
  logic [1:0]  sync1_q, sync2_q, prev_q, press_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] cnt_q, delay_d;
  logic [3:0]  pts1_q, pts2_q;
  logic        fs_q, p1vic_q, p2vic_q, go_q, false_q, over_q;

  assign press_d = sync2_q & ~prev_q;

  // LFSR next value (taps 16,14,13,11) and the random arm delay drawn from the current value
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    delay_d = DELAY_MIN + {16'd0, lfsr_q & DELAY_MASK};
  end

  // two-flop synchronizers for both buttons plus the previous level for rising-edge detect
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= {btn2_i, btn1_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // free-running LFSR, shifts every cycle regardless of state
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  // referee FSM; cnt_q is shared as delay, timeout and hold counter since they never overlap
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      pts1_q  <= 4'd0;
      pts2_q  <= 4'd0;
      fs_q    <= 1'b0;
      p1vic_q <= 1'b0;
      p2vic_q <= 1'b0;
      go_q    <= 1'b0;
      false_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      p1vic_q <= 1'b0;
      p2vic_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= WAIT;
          cnt_q   <= delay_d;
        end
        WAIT: if (press_d == 2'b11) begin
          cnt_q <= delay_d;
        end else if (press_d != 2'b00) begin
          state_q <= VERDICT;
          p1vic_q <= press_d[1];
          p2vic_q <= press_d[0];
          fs_q    <= 1'b1;
        end else if (cnt_q == 32'd0) begin
          state_q <= GO;
          go_q    <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 32'd1;
        end
        GO: if (press_d == 2'b11 || (press_d == 2'b00 && cnt_q == TIMEOUT - 32'd1)) begin
          state_q <= HOLD;
          go_q    <= 1'b0;
          cnt_q   <= 32'd0;
          fs_q    <= 1'b0;
        end else if (press_d != 2'b00) begin
          state_q <= VERDICT;
          go_q    <= 1'b0;
          p1vic_q <= press_d[0];
          p2vic_q <= press_d[1];
          fs_q    <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        VERDICT: begin
          state_q <= HOLD;
          cnt_q   <= 32'd0;
          false_q <= fs_q;
          pts1_q  <= pts1_q + {3'd0, p1vic_q & (pts1_q != WIN_POINTS)};
          pts2_q  <= pts2_q + {3'd0, p2vic_q & (pts2_q != WIN_POINTS)};
        end
        HOLD: if (cnt_q == HOLD_CYCLES - 32'd1) begin
          false_q <= 1'b0;
          fs_q    <= 1'b0;
          if (pts1_q == WIN_POINTS || pts2_q == WIN_POINTS) begin
            state_q <= MATCH_END;
            over_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
        MATCH_END: over_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p1vic_o       = p1vic_q;
  assign p2vic_o       = p2vic_q;
  assign go_led_o      = go_q;
  assign false_start_o = false_q;
  assign match_over_o  = over_q;
endmodule

// File: tb/tb_juiz_rodada.sv
// tb_juiz_rodada: scoreboard bench for the round referee with shortened timing parameters
module tb_juiz_rodada;
  logic clk, rst_n, start, btn1, btn2;
  logic p1vic, p2vic, go_led, false_start, match_over;
  logic [1:0] exp_q[$];
  logic prev_pulse;
  int n_chk, n_pass;

  juiz_rodada #(
    .DELAY_MIN(32'd4), .DELAY_MASK(16'h0003), .TIMEOUT(32'd20), .HOLD_CYCLES(32'd5), .WIN_POINTS(4'd8)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .btn1_i(btn1), .btn2_i(btn2),
    .p1vic_o(p1vic), .p2vic_o(p2vic), .go_led_o(go_led), .false_start_o(false_start),
    .match_over_o(match_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // pops an expected winner for every pulse seen
  always @(negedge clk) begin
    if (rst_n) begin
      if (p1vic | p2vic) begin
        if (exp_q.size() == 0) chk("unexpected_pulse", {30'd0, p2vic, p1vic}, 32'd0);
        else chk("pulse_winner", {30'd0, p2vic, p1vic}, {30'd0, exp_q.pop_front()});
        if (prev_pulse) chk("consecutive_pulse", 32'd1, 32'd0);
      end
      prev_pulse = p1vic | p2vic;
    end else prev_pulse = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_go();
    int n = 0;
    while (!go_led && n < 100) begin
      cyc(1);
      n++;
    end
    chk("go_seen", {31'd0, go_led}, 32'd1);
  endtask

  task automatic wait_pulse(output int lat, output logic go_at);
    lat = -1;
    go_at = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (p1vic | p2vic) begin
        lat = i;
        go_at = go_led;
        break;
      end
    end
  endtask

  // one round won in GO by player 1 (p2=0) or player 2 (p2=1)
  task automatic win_round(input logic p2, output int lat, output logic go_at);
    arm();
    wait_go();
    cyc(3);
    if (p2) btn2 = 1'b1;
    else btn1 = 1'b1;
    exp_q.push_back(p2 ? 2'b10 : 2'b01);
    wait_pulse(lat, go_at);
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(8);
  endtask

  initial begin
    int lat, fs_cnt, go_cnt, go_any;
    logic go_at;
    n_chk = 0;
    n_pass = 0;
    prev_pulse = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(3);
    chk("rst_outputs", {27'd0, p1vic, p2vic, go_led, false_start, match_over}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    win_round(1'b0, lat, go_at);
    chk("p1_latency", lat, 32'd3);
    chk("go_drop_at_pulse", {31'd0, go_at}, 32'd0);

    arm();
    btn2 = 1'b1;
    exp_q.push_back(2'b01);
    wait_pulse(lat, go_at);
    chk("fs_latency", lat, 32'd3);
    chk("fs_no_go", {31'd0, go_at}, 32'd0);
    btn2 = 1'b0;
    fs_cnt = 0;
    go_any = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      fs_cnt += int'(false_start);
      go_any += int'(go_led);
    end
    chk("fs_hold_len", fs_cnt, 32'd5);
    chk("fs_go_stays_low", go_any, 32'd0);

    arm();
    wait_go();
    btn1 = 1'b1;
    btn2 = 1'b1;
    cyc(3);
    chk("simul_go_off", {31'd0, go_led}, 32'd0);
    btn1 = 1'b0;
    btn2 = 1'b0;
    cyc(8);

    arm();
    wait_go();
    go_cnt = 1;
    for (int i = 0; i < 40 && go_led; i++) begin
      cyc(1);
      go_cnt += int'(go_led);
    end
    chk("timeout_go_len", go_cnt, 32'd20);
    cyc(8);

    btn1 = 1'b1;
    cyc(4);
    arm();
    wait_go();
    cyc(5);
    chk("held_no_event", {31'd0, go_led}, 32'd1);
    btn1 = 1'b0;
    cyc(2);
    btn1 = 1'b1;
    exp_q.push_back(2'b01);
    wait_pulse(lat, go_at);
    chk("held_new_edge", lat, 32'd3);
    btn1 = 1'b0;
    cyc(8);

    arm();
    wait_go();
    rst_n = 1'b0;
    #1;
    chk("async_rst", {28'd0, go_led, p1vic, p2vic, match_over}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    for (int r = 0; r < 8; r++) begin
      win_round(r == 3 ? 1'b1 : 1'b0, lat, go_at);
      if (r == 3) begin
        win_round(1'b0, lat, go_at);
      end
      if (r == 6) chk("match_not_over_7", {31'd0, match_over}, 32'd0);
    end
    chk("match_over_8", {31'd0, match_over}, 32'd1);
    arm();
    btn1 = 1'b1;
    cyc(30);
    chk("match_end_no_go", {31'd0, go_led}, 32'd0);
    chk("match_over_sticks", {31'd0, match_over}, 32'd1);
    btn1 = 1'b0;
    cyc(2);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
